// File: rtl/tpu_host_dma_pkg.sv
// Shared definitions for the host-side DMA: default widths, FSM state
// encoding and a small helper for "is this the final element" tests.
package tpu_host_dma_pkg;

  localparam int WORD_SIZE = 32;  // global-buffer word width
  localparam int DATA_SIZE = 8;   // global-buffer index width
  localparam int CNT_SIZE  = 9;   // word-count width, holds lengths up to 256

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_A     = 3'd1,
    LOAD_B     = 3'd2,
    START      = 3'd3,
    WAIT       = 3'd4,
    DRAIN_ADDR = 3'd5,
    DRAIN_DATA = 3'd6
  } state_e;

  // True when cnt addresses the final element of a len-long transfer.
  // A zero length never has a final element.
  function automatic logic at_last(input int unsigned cnt, input int unsigned len);
    return (len != 0) && (cnt == len - 1);
  endfunction

endpackage

// File: rtl/tpu_host_dma_gbuf_write_port.sv
// Write-side address generator for one global buffer. While enabled, every
// valid input word is strobed straight into the buffer at the current count;
// the count clears after the final word so the next job starts at index 0.
module gbuf_write_port
  import tpu_host_dma_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int IDX_W  = DATA_SIZE,
  parameter int CNT_W  = CNT_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              s_valid_i,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic [CNT_W-1:0]  len_i,
  output logic              wr_en_o,
  output logic [IDX_W-1:0]  index_o,
  output logic [WORD_W-1:0] data_o,
  output logic              last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire;

  assign fire    = en_i & s_valid_i;
  assign last_o  = fire & at_last(int'(cnt_q), int'(len_i));
  assign wr_en_o = fire;
  // Addresses wrap modulo the buffer depth; a 256-word load uses 0..255.
  assign index_o = cnt_q[IDX_W-1:0];
  // Write data is forced to zero when not strobing so the bus is quiet.
  assign data_o  = fire ? s_data_i : '0;

  // Next count: clear after the final word, advance on every accepted word.
  always_comb begin
    cnt_d = cnt_q;
    if (last_o) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Word counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tpu_host_dma.sv
// Host-side DMA for the TPU: loads A then B from a host stream into the
// input global buffers, kicks the TPU, waits for done, then drains the
// result buffer to the host one word per address/data cycle pair.
module tpu_host_dma
  import tpu_host_dma_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int IDX_W  = DATA_SIZE,
  parameter int CNT_W  = CNT_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_len_a,
  input  logic [CNT_W-1:0]  cfg_len_b,
  input  logic [CNT_W-1:0]  cfg_len_o,
  output logic              cfg_ready,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              wr_en_a,
  output logic [IDX_W-1:0]  index_a,
  output logic [WORD_W-1:0] data_out_a,
  output logic              wr_en_b,
  output logic [IDX_W-1:0]  index_b,
  output logic [WORD_W-1:0] data_out_b,
  output logic [IDX_W-1:0]  index_o,
  input  logic [WORD_W-1:0] data_in_o,
  output logic              start,
  input  logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_a_q, len_b_q, len_o_q;
  logic [CNT_W-1:0]  rdcnt_q;
  logic [IDX_W-1:0]  idx_hold_q;
  logic [WORD_W-1:0] m_data_q;
  logic              fresh_q;  // first DRAIN_DATA cycle: read data is on data_in_o now

  logic cfg_take, last_a, last_b, rd_last;

  assign cfg_take = (state_q == IDLE) & cfg_valid;
  assign rd_last  = at_last(int'(rdcnt_q), int'(len_o_q));

  gbuf_write_port #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == LOAD_A),
    .s_valid_i (s_valid),
    .s_data_i  (s_data),
    .len_i     (len_a_q),
    .wr_en_o   (wr_en_a),
    .index_o   (index_a),
    .data_o    (data_out_a),
    .last_o    (last_a)
  );

  gbuf_write_port #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == LOAD_B),
    .s_valid_i (s_valid),
    .s_data_i  (s_data),
    .len_i     (len_b_q),
    .wr_en_o   (wr_en_b),
    .index_o   (index_b),
    .data_o    (data_out_b),
    .last_o    (last_b)
  );

  // FSM state register; reset aborts any job and returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. Empty phases are skipped straight from the config
  // values so a zero-length job goes IDLE -> START -> WAIT -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_len_a != '0)      state_d = LOAD_A;
          else if (cfg_len_b != '0) state_d = LOAD_B;
          else                      state_d = START;
        end
      end
      LOAD_A: begin
        if (last_a) state_d = (len_b_q != '0) ? LOAD_B : START;
      end
      LOAD_B: begin
        if (last_b) state_d = START;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (done) state_d = (len_o_q != '0) ? DRAIN_ADDR : IDLE;
      end
      DRAIN_ADDR: state_d = DRAIN_DATA;
      DRAIN_DATA: begin
        if (m_ready) state_d = rd_last ? IDLE : DRAIN_ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. During the first DRAIN_DATA cycle the registered buffer
  // output is passed through directly; afterwards the captured copy is held
  // so m_data stays stable under backpressure.
  always_comb begin
    cfg_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    s_ready   = (state_q == LOAD_A) | (state_q == LOAD_B);
    start     = (state_q == START);
    m_valid   = (state_q == DRAIN_DATA);
    m_last    = (state_q == DRAIN_DATA) & rd_last;
    index_o   = (state_q == DRAIN_ADDR) ? rdcnt_q[IDX_W-1:0] : idx_hold_q;
    m_data    = ((state_q == DRAIN_DATA) && fresh_q) ? data_in_o : m_data_q;
  end

  // Job lengths, read counter, held read address and captured result word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_a_q    <= '0;
      len_b_q    <= '0;
      len_o_q    <= '0;
      rdcnt_q    <= '0;
      idx_hold_q <= '0;
      m_data_q   <= '0;
      fresh_q    <= 1'b0;
    end else begin
      fresh_q <= (state_q == DRAIN_ADDR);
      if (cfg_take) begin
        len_a_q <= cfg_len_a;
        len_b_q <= cfg_len_b;
        len_o_q <= cfg_len_o;
        rdcnt_q <= '0;
      end
      if ((state_q == WAIT) && done) begin
        rdcnt_q <= '0;
      end
      if ((state_q == DRAIN_DATA) && m_ready && !rd_last) begin
        rdcnt_q <= rdcnt_q + CNT_W'(1);
      end
      if (state_q == DRAIN_ADDR) begin
        idx_hold_q <= rdcnt_q[IDX_W-1:0];
      end
      if ((state_q == DRAIN_DATA) && fresh_q) begin
        m_data_q <= data_in_o;
      end
    end
  end

endmodule

// File: tb/tb_tpu_host_dma.sv
// Scoreboard bench for tpu_host_dma: the driver pushes the expected buffer
// writes and result words when it issues a job; a negedge monitor pops and
// compares them whenever the DUT strobes a write or completes a handshake.
module tb_tpu_host_dma;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 8;
  localparam int CNT_W  = 9;

  logic              clk;
  logic              rst;
  logic              cfg_valid;
  logic [CNT_W-1:0]  cfg_len_a, cfg_len_b, cfg_len_o;
  logic              cfg_ready;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              wr_en_a, wr_en_b;
  logic [IDX_W-1:0]  index_a, index_b, index_o;
  logic [WORD_W-1:0] data_out_a, data_out_b, data_in_o;
  logic              start, done;
  logic              m_valid, m_ready, m_last;
  logic [WORD_W-1:0] m_data;
  logic              busy;

  tpu_host_dma #(.WORD_W(WORD_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_len_a(cfg_len_a), .cfg_len_b(cfg_len_b),
    .cfg_len_o(cfg_len_o), .cfg_ready(cfg_ready),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en_a(wr_en_a), .index_a(index_a), .data_out_a(data_out_a),
    .wr_en_b(wr_en_b), .index_b(index_b), .data_out_b(data_out_b),
    .index_o(index_o), .data_in_o(data_in_o),
    .start(start), .done(done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result buffer model with a one-cycle registered read.
  logic [WORD_W-1:0] gbuf_o [256];
  always @(posedge clk) data_in_o <= gbuf_o[index_o];

  typedef struct { logic [IDX_W-1:0] idx; logic [WORD_W-1:0] data; } wr_t;
  typedef struct { logic [WORD_W-1:0] data; logic last; } rd_t;
  wr_t exp_a[$];
  wr_t exp_b[$];
  rd_t exp_m[$];

  logic [WORD_W-1:0] words [600];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int cfg_cyc = 0;
  int starts = 0;
  int exp_starts = 0;
  bit job_wr = 0;
  int mready_pct = 100;
  int done_dly = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // TPU model: done pulses done_dly cycles after each start pulse.
  initial begin
    done = 1'b0;
    forever begin
      @(negedge clk);
      if (start) begin
        for (int i = 0; i < done_dly; i++) @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
      end
    end
  end

  // Host sink readiness.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 m_ready = ($urandom_range(0, 99) < mready_pct);
    end
  end

  // Monitor: pops expectations on every write strobe / result handshake.
  initial begin
    wr_t e;
    rd_t r;
    bit pv_hold = 0;
    bit prev_start = 0;
    logic [WORD_W-1:0] pdata = '0;
    logic [IDX_W-1:0]  pidx = '0;
    logic              plast = 0;
    forever begin
      @(negedge clk);
      if (wr_en_a) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_a_extra: write idx %0h data %0h, required no write", index_a, data_out_a);
        end else begin
          e = exp_a.pop_front();
          chk("wr_a_idx", 64'(index_a), 64'(e.idx));
          chk("wr_a_data", 64'(data_out_a), 64'(e.data));
        end
        last_wr_cyc = cyc;
      end
      if (wr_en_b) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_b_extra: write idx %0h data %0h, required no write", index_b, data_out_b);
        end else begin
          e = exp_b.pop_front();
          chk("wr_b_idx", 64'(index_b), 64'(e.idx));
          chk("wr_b_data", 64'(data_out_b), 64'(e.data));
        end
        last_wr_cyc = cyc;
      end
      if (pv_hold) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(pdata));
        chk("hold_last", 64'(m_last), 64'(plast));
        chk("hold_index_o", 64'(index_o), 64'(pidx));
      end
      if (m_valid && m_ready) begin
        if (exp_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL m_extra: result %0h, required no result", m_data);
        end else begin
          r = exp_m.pop_front();
          chk("m_data", 64'(m_data), 64'(r.data));
          chk("m_last", 64'(m_last), 64'(r.last));
        end
      end
      pv_hold = m_valid && !m_ready;
      pdata = m_data;
      plast = m_last;
      pidx = index_o;
      if (start) begin
        chk("start_cycle", 64'(cyc), job_wr ? 64'(last_wr_cyc + 1) : 64'(cfg_cyc + 1));
        chk("start_single", 64'(prev_start), 64'd0);
        starts++;
      end
      prev_start = start;
      if (cfg_valid && cfg_ready) cfg_cyc = cyc;
      cyc++;
    end
  end

  // Issues one job and pushes its expected writes/results, then waits idle.
  task automatic run_job(input int la, input int lb, input int lo, input int stall,
                         input int mr, input int ddly, input bit pat, input bit bp);
    int k, n, hold;
    for (int i = 0; i < la; i++) exp_a.push_back('{IDX_W'(i % 256), words[i]});
    for (int i = 0; i < lb; i++) exp_b.push_back('{IDX_W'(i % 256), words[la + i]});
    for (int i = 0; i < lo; i++) exp_m.push_back('{gbuf_o[i % 256], (i == lo - 1)});
    job_wr = (la + lb) > 0;
    done_dly = ddly;
    mready_pct = bp ? 0 : mr;
    exp_starts++;
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_len_a = CNT_W'(la);
    cfg_len_b = CNT_W'(lb);
    cfg_len_o = CNT_W'(lo);
    @(negedge clk);
    chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    k = 0;
    n = 0;
    while (k < la + lb && n < 20000) begin
      if (pat) s_valid = !(n == 1 || n == 2);
      else     s_valid = ($urandom_range(0, 99) >= stall);
      s_data = words[k];
      @(negedge clk);
      if (s_valid && s_ready) k++;
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0;
    chk("stream_words", 64'(k), 64'(la + lb));
    n = 0;
    hold = 0;
    do begin
      @(negedge clk);
      n++;
      if (bp && m_valid && hold < 6) begin
        hold++;
        if (hold == 6) mready_pct = 100;
      end
    end while (busy && n < 20000);
    chk("job_finished", 64'(busy), 64'd0);
    chk("cfg_ready_end", 64'(cfg_ready), 64'd1);
    chk("a_left", 64'(exp_a.size()), 64'd0);
    chk("b_left", 64'(exp_b.size()), 64'd0);
    chk("m_left", 64'(exp_m.size()), 64'd0);
    chk("start_count", 64'(starts), 64'(exp_starts));
  endtask

  task automatic rand_fill(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
    for (int i = 0; i < 256; i++) gbuf_o[i] = $urandom;
  endtask

  initial begin
    int la, lb, lo;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_len_a = '0;
    cfg_len_b = '0;
    cfg_len_o = '0;
    s_valid = 1'b0;
    s_data = '0;
    for (int i = 0; i < 256; i++) gbuf_o[i] = '0;
    for (int i = 0; i < 600; i++) words[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_wr_en_a", 64'(wr_en_a), 64'd0);
    chk("rst_wr_en_b", 64'(wr_en_b), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_index_o", 64'(index_o), 64'd0);
    #2 rst = 1'b0;

    // Directed load/drain: byte-ramp words, two result words.
    for (int i = 0; i < 8; i++) words[i] = 32'h01020304 + 32'(i) * 32'h04040404;
    gbuf_o[0] = 32'h11;
    gbuf_o[1] = 32'h22;
    run_job(4, 4, 2, 0, 100, 10, 1'b0, 1'b0);

    // Input stall pattern 1,0,0,1 on a two-word A load.
    rand_fill(8);
    run_job(2, 0, 0, 0, 100, 2, 1'b1, 1'b0);

    // Result backpressure.
    rand_fill(8);
    run_job(1, 0, 3, 0, 100, 3, 1'b0, 1'b1);

    // All lengths zero; done arrives in the cycle right after start.
    run_job(0, 0, 0, 0, 100, 1, 1'b0, 1'b0);

    // Asynchronous reset in LOAD_B after two of four words.
    rand_fill(8);
    exp_b.push_back('{IDX_W'(0), words[0]});
    exp_b.push_back('{IDX_W'(1), words[1]});
    job_wr = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_len_a = '0;
    cfg_len_b = CNT_W'(4);
    cfg_len_o = CNT_W'(1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    s_valid = 1'b1;
    s_data = words[0];
    @(posedge clk); #1;
    s_data = words[1];
    @(posedge clk); #1;
    s_data = words[2];
    #1 rst = 1'b1;
    #1;
    chk("arst_wr_en_b", 64'(wr_en_b), 64'd0);
    chk("arst_s_ready", 64'(s_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("arst_start", 64'(start), 64'd0);
    chk("arst_b_left", 64'(exp_b.size()), 64'd0);
    s_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    rand_fill(8);
    run_job(0, 3, 1, 0, 100, 4, 1'b0, 1'b0);

    // Randomised jobs.
    for (int j = 0; j < 6; j++) begin
      la = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      lb = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      lo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      rand_fill(la + lb);
      run_job(la, lb, lo, int'($urandom_range(0, 50)), int'($urandom_range(30, 100)),
              int'($urandom_range(1, 12)), 1'b0, 1'b0);
    end

    // Full-depth transfers: 256 words address 0..255 exactly once.
    rand_fill(259);
    run_job(256, 3, 256, 20, 70, 5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
